// File: rtl/mul_defs.sv
// Shared definitions for the multiplier chain: product width, accumulator
// state encoding and a constant-evaluable ceil(log2) helper.
package mul_defs;

  localparam int MUL_OUT_W = 17;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mul_accumulator.sv
// Sums LEN unsigned product samples and presents sum and truncated mean.
// Result valid the cycle after the LEN-th accept; HOLD stalls input until out_ready.
module mul_accumulator
  import mul_defs::*;
#(
  parameter  int IN_W  = MUL_OUT_W,
  parameter  int LEN   = 8,
  localparam int CNT_W = clog2(LEN),
  localparam int OUT_W = IN_W + clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic [IN_W-1:0]  out_mean
);

  state_t             r_state;
  logic [OUT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_sum;
  logic [IN_W-1:0]    r_mean;
  logic [OUT_W-1:0]   w_sum_next;

  // OUT_W carries log2(LEN) guard bits, so this add can never wrap.
  assign w_sum_next = r_acc + OUT_W'(in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_mean      <= '0;
    end else if (clear) begin
      // Last result stays visible on out_sum/out_mean; only the valid drops.
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (in_valid) begin
            if (r_cnt == CNT_W'(LEN - 1)) begin
              r_sum       <= w_sum_next;
              r_mean      <= w_sum_next[OUT_W-1:CNT_W];
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_acc <= w_sum_next;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_mean  = r_mean;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator with LEN=8, IN_W=17.
module tb_mul_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [16:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_sum;
  logic [16:0] out_mean;

  int n_tests = 0;
  int n_fail  = 0;

  mul_accumulator #(.IN_W(17), .LEN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_mean  (out_mean)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample and holds it until the DUT accepts it (bounded).
  task automatic push(input logic [16:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk("push_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [16:0] d);
    for (int i = 0; i < n; i++) push(d);
  endtask

  // Checks a pending result, then lets one edge pass with out_ready high.
  task automatic take(input string tag, input logic [31:0] sum, input logic [31:0] mean);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_rdy0"}, 32'(in_ready), 32'd0);
    chk({tag, "_sum"}, 32'(out_sum), sum);
    chk({tag, "_mean"}, 32'(out_mean), mean);
    out_ready = 1'b1;
    tick();
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy1"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_mean", 32'(out_mean), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Back-to-back 1..8.
    for (int i = 1; i <= 8; i++) push(17'(i));
    take("seq", 32'd36, 32'd4);

    // Full-scale samples: no wrap.
    push_n(8, 17'd131071);
    take("max", 32'd1048568, 32'd131071);

    // Backpressure: 8x7 held for 5 cycles with an upstream sample waiting.
    out_ready = 1'b0;
    push_n(8, 17'd7);
    in_valid = 1'b1;
    in_data  = 17'd99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(out_sum), 32'd56);
      tick();
    end
    take("bp", 32'd56, 32'd7);
    push(17'd99);
    push_n(7, 17'd1);
    take("bp_next", 32'd106, 32'd13);

    // Clear mid-block discards partial data.
    push_n(3, 17'd100);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push_n(8, 17'd10);
    take("clr", 32'd80, 32'd10);

    // Clear in HOLD together with out_ready: valid drops, value retained.
    out_ready = 1'b0;
    push_n(8, 17'd2);
    chk("clrh_vld", 32'(out_valid), 32'd1);
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrh_vld_drop", 32'(out_valid), 32'd0);
    chk("clrh_rdy", 32'(in_ready), 32'd1);
    chk("clrh_sum_kept", 32'(out_sum), 32'd16);
    chk("clrh_mean_kept", 32'(out_mean), 32'd2);

    // 1..8 with idle gaps between samples.
    for (int i = 1; i <= 8; i++) begin
      int gap;
      gap = ((i * 3) % 4) + int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      push(17'(i));
    end
    take("gap", 32'd36, 32'd4);

    // Async reset mid-block.
    push_n(3, 17'd50);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc_rdy", 32'(in_ready), 32'd1);
    chk("arst_acc_vld", 32'(out_valid), 32'd0);
    chk("arst_acc_sum", 32'(out_sum), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Async reset while holding a result.
    out_ready = 1'b0;
    push_n(8, 17'd3);
    chk("arst_hold_vld_pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hold_vld", 32'(out_valid), 32'd0);
    chk("arst_hold_rdy", 32'(in_ready), 32'd1);
    chk("arst_hold_sum", 32'(out_sum), 32'd0);
    chk("arst_hold_mean", 32'(out_mean), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    push_n(8, 17'd5);
    take("post_rst", 32'd40, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_accumulator.md
# mul_accumulator

Downstream consumer of the product stage in the multiplier chain. Accepts a stream of 17-bit unsigned products, sums `LEN` consecutive samples without overflow, and presents both the full sum and the truncated mean through a valid/ready output. Used to average `a*b+c` results before they are displayed or logged.

## Interface
Parameters:
- `IN_W`, 17: width of incoming product samples (unsigned).
- `LEN`, 8: samples per accumulation block; power of two, 2..256.
- `CNT_W`, $clog2(LEN): sample counter width (derived, not overridden).
- `OUT_W`, IN_W + $clog2(LEN): sum width (derived; guarantees no overflow).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort: discard partial or pending block.
- `in_valid`  in  1  `in_data` valid this cycle.
- `in_data`  in  IN_W  product sample, unsigned.
- `in_ready`  out  1  block can accept a sample this cycle.
- `out_valid`  out  1  `out_sum`/`out_mean` hold a completed block.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_sum`  out  OUT_W  sum of the `LEN` samples.
- `out_mean`  out  IN_W  `out_sum >> $clog2(LEN)`, truncated.

## Operation
- States: `ACCUM` (collecting) and `HOLD` (result pending). Reset and `clear` enter `ACCUM` with `acc=0`, `cnt=0`.
- `ACCUM`: `in_ready=1`. Transfer when `in_valid && in_ready`: `acc <= acc + in_data`, `cnt <= cnt + 1`. No transfer: nothing changes; gaps in `in_valid` of any length are allowed.
- Transfer with `cnt == LEN-1`: `out_sum <= acc + in_data`, `out_mean` from the same value, `acc <= 0`, `cnt <= 0`, go to `HOLD`.
- `HOLD`: `in_ready=0`, `out_valid=1`. `out_sum`/`out_mean` stay stable until `out_valid && out_ready`, then return to `ACCUM` with `out_valid=0`.
- `clear` has priority over every other event. A sample presented in the same cycle is dropped. A pending `HOLD` result is discarded. `out_sum`/`out_mean` keep their last value but `out_valid` falls.
- Arithmetic is unsigned, full width. Sum range 0..LEN*(2^IN_W-1). Mean truncates, never rounds.
- `in_ready` and `out_valid` are pure functions of state; neither depends combinationally on `in_valid`/`out_ready`.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_mean=0`, state `ACCUM`, `acc=0`, `cnt=0`. Reset takes effect immediately and asynchronously. Asserting it mid-block loses all partial data.
- Latency: `out_valid` rises on the clock edge that accepts the `LEN`-th sample, i.e. it is visible the cycle after that sample is presented.
- Minimum block period: `LEN` accept cycles plus 1 `HOLD` cycle. With `out_ready` held high there is one `in_ready=0` bubble per block.
- Backpressure: `HOLD` may last indefinitely. The upstream stage must hold its sample while `in_ready=0`.
- Clear and output handshake in the same cycle: clear wins and the result is not counted as delivered.

## Structure
- Shared header/package `mul_defs`:
  - state encoding (`ST_ACCUM`, `ST_HOLD`);
  - `MUL_OUT_W=17` so the product stage and this block agree on width;
  - a `clog2` helper.
- Single module, no sub-modules. The counter and the adder are too small to split.

## Test plan
- Feed samples 1..8, back-to-back, `out_ready=1`: `out_valid` for one cycle, `out_sum=36`, `out_mean=4`, then `in_ready=1` again.
- Feed 8 samples of 131071 (max): `out_sum=1048568`, `out_mean=131071`, no wrap.
- Complete a block with `out_ready=0` for 5 cycles: `out_sum` stable, `in_ready=0` throughout, the held upstream sample is accepted only after the handshake.
- Feed 3 samples of 100, pulse `clear`, then 8 samples of 10: `out_sum=80`, `out_mean=10`. The cleared samples never appear.
- Feed samples 1..8 with random `in_valid` gaps: same result as the back-to-back case (36/4). `cnt` only advances on transfers.
- Deassert `rst_n` asynchronously mid-block and in `HOLD`: outputs immediately return to their reset values. The next full block of 8×5 gives `out_sum=40`.
